// File: rtl/conv_writeback_serializer.sv
// Captures LANES lane results and writes them one byte per cycle into the feature RAM.
// Optional RELU_EN macro clamps negative lanes to zero at the wr_data register.
module conv_writeback_serializer #(
  parameter int LANES = 16,
  parameter int DW    = 8,
  parameter int AW    = 14
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start_write_back,
  input  logic                stop_write_back,
  input  logic [LANES*DW-1:0] u_bus,
  input  logic                addr_load,
  input  logic [AW-1:0]       addr_init,
  output logic                wr_en,
  output logic [AW-1:0]       ram_store_addr,
  output logic [DW-1:0]       wr_data,
  output logic                busy,
  output logic                done
);

  localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [IW-1:0] LAST = IW'(LANES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_ptr_q, addr_ptr_d;
  logic [IW-1:0]   lane_idx_q, lane_idx_d;
  logic [DW-1:0]   shadow_q [LANES];
  logic            capture;
  logic            wr_en_d, done_d;
  logic [AW-1:0]   addr_d;
  logic [DW-1:0]   data_d;
  logic [DW-1:0]   lane_byte;

  assign lane_byte = shadow_q[lane_idx_q];

  always_comb begin
    state_d    = state_q;
    addr_ptr_d = addr_ptr_q;
    lane_idx_d = lane_idx_q;
    capture    = 1'b0;
    wr_en_d    = 1'b0;
    done_d     = 1'b0;
    addr_d     = ram_store_addr;
    data_d     = wr_data;
    unique case (state_q)
      S_IDLE: begin
        if (addr_load)
          addr_ptr_d = addr_init;
        if (start_write_back) begin
          capture    = 1'b1;
          lane_idx_d = '0;
          state_d    = S_WRITE;
        end
      end
      S_WRITE: begin
        // An abort leaves the pointer on the first unwritten address.
        if (stop_write_back) begin
          state_d = S_DONE;
        end else begin
          wr_en_d    = 1'b1;
          addr_d     = addr_ptr_q;
`ifdef RELU_EN
          data_d     = lane_byte[DW-1] ? '0 : lane_byte;
`else
          data_d     = lane_byte;
`endif
          lane_idx_d = lane_idx_q + 1'b1;
          addr_ptr_d = addr_ptr_q + 1'b1;
          if (lane_idx_q == LAST)
            state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      addr_ptr_q     <= '0;
      lane_idx_q     <= '0;
      wr_en          <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      ram_store_addr <= '0;
      wr_data        <= '0;
    end else begin
      state_q        <= state_d;
      addr_ptr_q     <= addr_ptr_d;
      lane_idx_q     <= lane_idx_d;
      wr_en          <= wr_en_d;
      busy           <= wr_en_d;
      done           <= done_d;
      ram_store_addr <= addr_d;
      wr_data        <= data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < LANES; k++)
        shadow_q[k] <= '0;
    end else if (capture) begin
      for (int k = 0; k < LANES; k++)
        shadow_q[k] <= u_bus[k*DW +: DW];
    end
  end

endmodule

// File: tb/tb_conv_writeback_serializer.sv
// Scoreboard bench for conv_writeback_serializer.
// Expected writes/done pulses are queued by stimulus and checked by a monitor.
`timescale 1ns/1ps
module tb_conv_writeback_serializer;

  logic         clk = 1'b0;
  logic         reset;
  logic         start_write_back;
  logic         stop_write_back;
  logic [127:0] u_bus;
  logic         addr_load;
  logic [13:0]  addr_init;
  logic         wr_en;
  logic [13:0]  ram_store_addr;
  logic [7:0]   wr_data;
  logic         busy;
  logic         done;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          is_done;
    logic [13:0] addr;
    logic [7:0]  data;
  } ev_t;

  ev_t        sb[$];
  logic [7:0] lanes [16];

  conv_writeback_serializer dut (
    .clk              (clk),
    .reset            (reset),
    .start_write_back (start_write_back),
    .stop_write_back  (stop_write_back),
    .u_bus            (u_bus),
    .addr_load        (addr_load),
    .addr_init        (addr_init),
    .wr_en            (wr_en),
    .ram_store_addr   (ram_store_addr),
    .wr_data          (wr_data),
    .busy             (busy),
    .done             (done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] exp_byte(input logic [7:0] b);
`ifdef RELU_EN
    return b[7] ? 8'h00 : b;
`else
    return b;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic set_bus();
    for (int k = 0; k < 16; k++)
      u_bus[k*8 +: 8] = lanes[k];
  endtask

  task automatic push_burst(input logic [13:0] base, input int n,
                            input bit with_done);
    ev_t e;
    for (int i = 0; i < n; i++) begin
      e.is_done = 1'b0;
      e.addr    = base + 14'(i);
      e.data    = exp_byte(lanes[i]);
      sb.push_back(e);
    end
    if (with_done) begin
      e.is_done = 1'b1;
      e.addr    = '0;
      e.data    = '0;
      sb.push_back(e);
    end
  endtask

  task automatic pulse_start(input bit load, input logic [13:0] init);
    @(posedge clk);
    #1;
    start_write_back = 1'b1;
    addr_load        = load;
    addr_init        = init;
    @(posedge clk);
    #1;
    start_write_back = 1'b0;
    addr_load        = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    ev_t e;
    if (wr_en !== busy)
      chk("busy_vs_wr_en", {31'd0, busy}, {31'd0, wr_en});
    if (wr_en === 1'b1 || done === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_event: wr_en=%0b done=%0b addr=%0h",
                 wr_en, done, ram_store_addr);
      end else begin
        e = sb.pop_front();
        if (e.is_done) begin
          chk("done_pulse", {30'd0, wr_en, done}, 32'h1);
        end else begin
          chk("wr_en", {31'd0, wr_en}, 32'h1);
          chk("wr_addr", {18'd0, ram_store_addr}, {18'd0, e.addr});
          chk("wr_data", {24'd0, wr_data}, {24'd0, e.data});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset            = 1'b1;
    start_write_back = 1'b0;
    stop_write_back  = 1'b0;
    addr_load        = 1'b0;
    addr_init        = '0;
    u_bus            = '0;
    wait_cycles(3);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_wr_en", {31'd0, wr_en}, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'h0);
    chk("rst_done", {31'd0, done}, 32'h0);
    chk("rst_addr", {18'd0, ram_store_addr}, 32'h0);
    chk("rst_data", {24'd0, wr_data}, 32'h0);

    // load with start: first write at addr_init
    for (int k = 0; k < 16; k++) lanes[k] = 8'(k + 1);
    set_bus();
    push_burst(14'h0100, 16, 1);
    pulse_start(1'b1, 14'h0100);
    wait_cycles(17);

    // pointer persists
    for (int k = 0; k < 16; k++) lanes[k] = 8'(8'h30 + k);
    set_bus();
    push_burst(14'h0110, 16, 1);
    pulse_start(1'b0, 14'h0000);
    wait_cycles(17);

    // address wrap
    for (int k = 0; k < 16; k++) lanes[k] = 8'(8'h10 + k);
    set_bus();
    push_burst(14'h3FF8, 16, 1);
    pulse_start(1'b1, 14'h3FF8);
    wait_cycles(17);

    // abort on 5th write cycle
    for (int k = 0; k < 16; k++) lanes[k] = 8'(8'h40 + k);
    set_bus();
    push_burst(14'h0008, 4, 1);
    pulse_start(1'b0, 14'h0000);
    wait_cycles(4);
    stop_write_back = 1'b1;
    wait_cycles(1);
    stop_write_back = 1'b0;
    wait_cycles(3);
    for (int k = 0; k < 16; k++) lanes[k] = 8'(8'h50 + k);
    set_bus();
    push_burst(14'h000C, 16, 1);
    pulse_start(1'b0, 14'h0000);
    wait_cycles(17);

    // start, addr_load and u_bus changes mid-burst are ignored
    for (int k = 0; k < 16; k++) lanes[k] = 8'(8'h60 + k);
    set_bus();
    push_burst(14'h001C, 16, 1);
    pulse_start(1'b0, 14'h0000);
    wait_cycles(3);
    for (int k = 0; k < 16; k++) lanes[k] = 8'(8'h70 + k);
    set_bus();
    start_write_back = 1'b1;
    addr_load        = 1'b1;
    addr_init        = 14'h2000;
    wait_cycles(1);
    start_write_back = 1'b0;
    addr_load        = 1'b0;
    wait_cycles(13);

    // reset mid-burst: three writes, then nothing, no done
    for (int k = 0; k < 16; k++) lanes[k] = 8'(8'h21 + k);
    set_bus();
    push_burst(14'h002C, 3, 0);
    pulse_start(1'b0, 14'h0000);
    wait_cycles(3);
    reset = 1'b1;
    wait_cycles(1);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_wr_en", {31'd0, wr_en}, 32'h0);
    chk("midrst_addr", {18'd0, ram_store_addr}, 32'h0);
    wait_cycles(20);

    // pointer back at 0; signed-looking bytes
    lanes[0] = 8'h80;
    lanes[1] = 8'hFF;
    for (int k = 2; k < 16; k++) lanes[k] = 8'(8'h02 + k);
    lanes[7] = 8'hC3;
    set_bus();
    push_burst(14'h0000, 16, 1);
    pulse_start(1'b0, 14'h0000);
    wait_cycles(20);

    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
